// File: rtl/instr_fetch_reg_if.sv
// Fetch-stage bundle: instruction-memory handshake, redirect input and the
// instruction-register outputs consumed by the immediate sign-extender.
interface instr_fetch_reg_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        consume;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] Instr31_0;
    logic [2:0]  InstrType;
    logic [63:0] pc_out;
    logic        fetch_err;

    modport master (
        output mem_req, mem_addr, instr_valid, Instr31_0, InstrType, pc_out, fetch_err,
        input  mem_ack, mem_rdata, consume, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, Instr31_0, InstrType, pc_out, fetch_err,
        output mem_ack, mem_rdata, consume, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time over req/ack,
// holds it with its immediate-format code until consumed, and accepts PC redirects.
module instr_fetch_reg #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    instr_fetch_reg_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [63:0] pc_q;
    logic [31:0] timeout_q;
    logic [31:0] instr_q;
    logic [2:0]  instr_type_q;
    logic [63:0] pc_out_q;
    logic        instr_valid_q;
    logic        fetch_err_q;
    logic [2:0]  instr_type_d;

    // Immediate-format code from the opcode field; non-32-bit encodings fall to "none".
    function automatic logic [2:0] decode_type(input logic [31:0] word);
        logic [2:0] code;
        case (word[6:0])
            7'b1100011: code = 3'b000;
            7'b0100011: code = 3'b001;
            7'b0000011: code = 3'b010;
            7'b0010011: code = 3'b011;
            7'b1100111: code = 3'b100;
            default:    code = 3'b111;
        endcase
        return code;
    endfunction

    // Decode the incoming memory word so it lands in the register alongside the instruction.
    always_comb begin
        instr_type_d = decode_type(bus.mem_rdata);
    end

    // Fetch FSM with PC, timeout counter and the instruction register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            timeout_q     <= 32'd0;
            instr_q       <= 32'd0;
            instr_type_q  <= 3'b111;
            pc_out_q      <= 64'd0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect wins over any ack or consume arriving in the same cycle.
            instr_valid_q <= 1'b0;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                pc_q        <= bus.redirect_pc;
                fetch_err_q <= 1'b0;
                timeout_q   <= 32'd0;
                state_q     <= FETCH;
            end else begin
                fetch_err_q <= 1'b1;
                state_q     <= ERROR;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 32'd0;
                    state_q   <= FETCH;
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        instr_q       <= bus.mem_rdata;
                        instr_type_q  <= instr_type_d;
                        pc_out_q      <= pc_q;
                        pc_q          <= pc_q + 64'd4;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end else if (timeout_q == TIMEOUT_LAST) begin
                        fetch_err_q <= 1'b1;
                        state_q     <= ERROR;
                    end else begin
                        timeout_q <= timeout_q + 32'd1;
                    end
                end
                HOLD: begin
                    if (bus.consume) begin
                        instr_valid_q <= 1'b0;
                        timeout_q     <= 32'd0;
                        state_q       <= FETCH;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                ERROR: begin
                    fetch_err_q   <= 1'b1;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req     = (state_q == FETCH);
    assign bus.mem_addr    = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.Instr31_0   = instr_q;
    assign bus.InstrType   = instr_type_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg: reset, fetch/hold/consume, redirect races,
// decode sweep, misaligned redirect, timeout, PC wrap and asynchronous reset.
module tb_instr_fetch_reg;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    instr_fetch_reg_if bus ();

    instr_fetch_reg #(
        .RESET_PC       (64'h0),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [31:0] words [5] = '{32'h00C58463, 32'h00B12023, 32'h00012503, 32'h00008067, 32'h0000006F};
    logic [2:0]  types [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};

    initial begin
        total = 0;
        bad   = 0;
        clock = 1'b0;
        reset = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'd0;
        bus.consume     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'd0;

        #3;
        check_val("rst_req",   {63'd0, bus.mem_req}, 64'd0);
        check_val("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("rst_type",  {61'd0, bus.InstrType}, 64'd7);
        check_val("rst_instr", {32'd0, bus.Instr31_0}, 64'd0);
        check_val("rst_err",   {63'd0, bus.fetch_err}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Cycle 1 after release is IDLE, then FETCH at RESET_PC.
        check_val("idle_req", {63'd0, bus.mem_req}, 64'd0);
        tick();
        check_val("fetch_req", {63'd0, bus.mem_req}, 64'd1);
        check_val("fetch_addr", bus.mem_addr, 64'h0);

        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00500093;
        tick();
        bus.mem_ack = 1'b0;
        check_val("ld_valid", {63'd0, bus.instr_valid}, 64'd1);
        check_val("ld_instr", {32'd0, bus.Instr31_0}, 64'h00500093);
        check_val("ld_type",  {61'd0, bus.InstrType}, 64'd3);
        check_val("ld_pcout", bus.pc_out, 64'h0);
        check_val("ld_addr",  bus.mem_addr, 64'h4);
        check_val("ld_req",   {63'd0, bus.mem_req}, 64'd0);

        // Stall in HOLD: nothing moves, no request.
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check_val("stall_req",   {63'd0, bus.mem_req}, 64'd0);
        check_val("stall_valid", {63'd0, bus.instr_valid}, 64'd1);
        check_val("stall_instr", {32'd0, bus.Instr31_0}, 64'h00500093);

        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        check_val("cons_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("cons_req",   {63'd0, bus.mem_req}, 64'd1);
        check_val("cons_addr",  bus.mem_addr, 64'h4);

        // Redirect racing an ack: the word is dropped.
        bus.mem_ack     = 1'b1;
        bus.mem_rdata   = 32'hFE000EE3;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h100;
        tick();
        bus.mem_ack  = 1'b0;
        bus.redirect = 1'b0;
        check_val("race_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("race_instr", {32'd0, bus.Instr31_0}, 64'h00500093);
        check_val("race_req",   {63'd0, bus.mem_req}, 64'd1);
        check_val("race_addr",  bus.mem_addr, 64'h100);

        // Decode sweep from 0x100 upward.
        for (int i = 0; i < 5; i++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = words[i];
            tick();
            bus.mem_ack = 1'b0;
            check_val($sformatf("dec_type%0d", i), {61'd0, bus.InstrType}, {61'd0, types[i]});
            check_val($sformatf("dec_pc%0d", i), bus.pc_out, 64'h100 + 64'(4 * i));
            bus.consume = 1'b1;
            tick();
            bus.consume = 1'b0;
        end

        // Load one more (pc 0x114) and hit a misaligned redirect in HOLD.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00500093;
        tick();
        bus.mem_ack     = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h102;
        tick();
        bus.redirect = 1'b0;
        check_val("mis_err",   {63'd0, bus.fetch_err}, 64'd1);
        check_val("mis_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("mis_req",   {63'd0, bus.mem_req}, 64'd0);
        check_val("mis_addr",  bus.mem_addr, 64'h118);

        // Aligned redirect leaves ERROR, then let the fetch time out.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h300;
        tick();
        bus.redirect = 1'b0;
        check_val("rec_err",  {63'd0, bus.fetch_err}, 64'd0);
        check_val("rec_addr", bus.mem_addr, 64'h300);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check_val("to_pre_err", {63'd0, bus.fetch_err}, 64'd0);
        check_val("to_pre_req", {63'd0, bus.mem_req}, 64'd1);
        tick();
        check_val("to_err", {63'd0, bus.fetch_err}, 64'd1);
        check_val("to_req", {63'd0, bus.mem_req}, 64'd0);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h200;
        tick();
        bus.redirect = 1'b0;
        check_val("to_rec_err",  {63'd0, bus.fetch_err}, 64'd0);
        check_val("to_rec_req",  {63'd0, bus.mem_req}, 64'd1);
        check_val("to_rec_addr", bus.mem_addr, 64'h200);

        // Consume with nothing held is ignored.
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        check_val("noval_req",  {63'd0, bus.mem_req}, 64'd1);
        check_val("noval_addr", bus.mem_addr, 64'h200);

        // PC wraps at the top of the address space.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus.redirect  = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00008067;
        tick();
        bus.mem_ack = 1'b0;
        check_val("wrap_pcout", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_addr",  bus.mem_addr, 64'h0);

        // Asynchronous reset in the middle of a FETCH.
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        check_val("pre_rst_req", {63'd0, bus.mem_req}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_req",   {63'd0, bus.mem_req}, 64'd0);
        check_val("arst_addr",  bus.mem_addr, 64'h0);
        check_val("arst_instr", {32'd0, bus.Instr31_0}, 64'h0);
        check_val("arst_type",  {61'd0, bus.InstrType}, 64'd7);
        check_val("arst_pcout", bus.pc_out, 64'h0);
        check_val("arst_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("arst_err",   {63'd0, bus.fetch_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
